// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: decodes ir_m and drives a req/ack data bus, extending load data.
// Holds stall_m through IDLE/WAIT (min 3 cycles per memory op); flags misalignment and bus timeout.
module mem_access_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir_m,
    input  logic [31:0] pc4_m,
    input  logic [31:0] alu_out_m,
    input  logic [31:0] rt_m,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall_m,
    output logic [31:0] load_data_m,
    output logic        load_valid,
    output logic        addr_exc,
    output logic        bus_err,
    output logic [31:0] exc_pc
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               err_q;
    logic [31:0]        load_q;

    logic        is_load;
    logic        is_store;
    logic        sgn;
    logic [1:0]  sz;
    logic        is_mem;
    logic        aligned;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ext;
    logic        in_req;
    logic        unused_ir;

    assign unused_ir = ^ir_m[25:0];

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sgn      = 1'b0;
        sz       = SZ_W;
        case (ir_m[31:26])
            OP_LB:   begin is_load  = 1'b1; sz = SZ_B; sgn = 1'b1; end
            OP_LH:   begin is_load  = 1'b1; sz = SZ_H; sgn = 1'b1; end
            OP_LW:   begin is_load  = 1'b1; sz = SZ_W; end
            OP_LBU:  begin is_load  = 1'b1; sz = SZ_B; end
            OP_LHU:  begin is_load  = 1'b1; sz = SZ_H; end
            OP_SB:   begin is_store = 1'b1; sz = SZ_B; end
            OP_SH:   begin is_store = 1'b1; sz = SZ_H; end
            OP_SW:   begin is_store = 1'b1; sz = SZ_W; end
            default: ;
        endcase
    end

    assign is_mem = is_load | is_store;

    always_comb begin
        aligned = 1'b1;
        be      = 4'b1111;
        wdata   = 32'h0;
        case (sz)
            SZ_B: begin
                be = 4'b0001 << alu_out_m[1:0];
                if (is_store) wdata = {4{rt_m[7:0]}};
            end
            SZ_H: begin
                aligned = ~alu_out_m[0];
                be      = alu_out_m[1] ? 4'b1100 : 4'b0011;
                if (is_store) wdata = {2{rt_m[15:0]}};
            end
            default: begin
                aligned = (alu_out_m[1:0] == 2'b00);
                if (is_store) wdata = rt_m;
            end
        endcase
    end

    // Lane select by byte offset, then extend per size/signedness.
    assign rd_byte = mem_rdata[{alu_out_m[1:0], 3'b000} +: 8];
    assign rd_half = alu_out_m[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        case (sz)
            SZ_B:    ext = sgn ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
            SZ_H:    ext = sgn ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
            default: ext = mem_rdata;
        endcase
    end

    // Outputs are forced low during reset so nothing leaks while the FSM is being cleared.
    assign in_req      = ~reset & is_mem & aligned & (state == S_IDLE || state == S_WAIT);
    assign mem_req     = in_req;
    assign stall_m     = in_req;
    assign mem_we      = in_req & is_store;
    assign mem_addr    = in_req ? {alu_out_m[31:2], 2'b00} : 32'h0;
    assign mem_be      = in_req ? be : 4'b0000;
    assign mem_wdata   = in_req ? wdata : 32'h0;
    assign addr_exc    = ~reset & (state == S_IDLE) & is_mem & ~aligned;
    assign load_valid  = ~reset & (state == S_DONE) & is_load & ~err_q;
    assign bus_err     = ~reset & (state == S_DONE) & err_q;
    assign exc_pc      = (addr_exc | bus_err) ? (pc4_m - 32'd4) : 32'h0;
    assign load_data_m = reset ? 32'h0 : load_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            err_q  <= 1'b0;
            load_q <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_mem && aligned) begin
                        state <= S_WAIT;
                        cnt   <= '0;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    // Ack on the timeout boundary still completes cleanly.
                    if (mem_ack) begin
                        if (is_load) load_q <= ext;
                        state <= S_DONE;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    err_q <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
